regfile_write_sched: RTL

// Owns the single write port of the 16x8 register file. Arbitrates between two

---
 rtl/regfile_write_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regfile_write_sched.sv
// -----------------------------------------------------------------------------
// regfile_write_sched
//
// Owns the single write port of the register file. Arbitrates between two
// writeback requesters, A (execute) and B (load/memory), and runs a hardware
// clear walk that zeroes every register after reset or on request.
//
// Ports
//   clk               in   1       clock, single domain
//   sync_rst          in   1       synchronous reset, active-high, beats clk_en
//   clk_en            in   1       global clock enable; all state holds while low
//   a_req/a_addr/a_data in         requester A write request
//   a_ack             out  1       A accepted this cycle (combinational)
//   b_req/b_addr/b_data in         requester B write request
//   b_ack             out  1       B accepted this cycle (combinational)
//   clear_req         in   1       pulse: zero the whole register file
//   busy              out  1       high while the clear walk is running
//   rf_write_address  out  ADDR_W  registered regfile write address
//   rf_write_data     out  DATA_W  registered regfile write data
//   rf_write_en       out  1       registered regfile write enable
// -----------------------------------------------------------------------------
module regfile_write_sched #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              clk_en,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    input  logic              clear_req,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              rr_pref;   // 0 = A preferred on a tie, 1 = B

    logic              grant_ok;
    logic              pick_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign busy = (state == CLEAR);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        grant_ok = 1'b0;
        pick_b   = 1'b0;
        a_ack    = 1'b0;
        b_ack    = 1'b0;
        sel_addr = a_addr;
        sel_data = a_data;

        // clear_req beats both requesters; nothing is granted while held in reset.
        grant_ok = (state == RUN) && clk_en && !clear_req && !sync_rst;
        // B wins when alone, or on a tie when round-robin currently favours B.
        pick_b   = b_req && (!a_req || ((RR_EN != 0) && rr_pref));
        a_ack    = grant_ok && a_req && !pick_b;
        b_ack    = grant_ok && b_req && pick_b;
        if (pick_b) begin
            sel_addr = b_addr;
            sel_data = b_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state            <= CLEAR;
            clr_cnt          <= '0;
            rr_pref          <= 1'b0;
            rf_write_en      <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
        end else if (clk_en) begin
            case (state)
                CLEAR: begin
                    rf_write_en      <= 1'b1;
                    rf_write_address <= clr_cnt;
                    rf_write_data    <= '0;
                    clr_cnt          <= clr_cnt + CNT_ONE;
                    if (clr_cnt == '1) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state       <= CLEAR;
                        clr_cnt     <= '0;
                        rf_write_en <= 1'b0;
                    end else if (a_ack || b_ack) begin
                        rf_write_address <= sel_addr;
                        rf_write_data    <= sel_data;
                        // Register 0 is hard-zero: the grant is consumed but not written.
                        rf_write_en      <= (sel_addr != '0);
                        // After a grant the other side is preferred; fixed at A otherwise.
                        rr_pref          <= (RR_EN != 0) && a_ack;
                    end else begin
                        rf_write_en <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule
